// File: rtl/bit_serial_gate_ctrl_pkg.sv
// Shared constants and types for the bit-serial gate controller:
// opcode encodings, FSM state encoding and the default operand width.
package bit_serial_gate_ctrl_pkg;

  localparam int WIDTH_DEFAULT = 8;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_XNOR = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Opcodes above XNOR carry no gate function and are reported as errors.
  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_XNOR;
  endfunction

endpackage

// File: rtl/bit_serial_gate_ctrl_if.sv
// Request/response bundle between two requesters, the controller and the result consumer.
// master = requester/consumer side, slave = the controller.
interface bit_serial_gate_ctrl_if #(
  parameter int WIDTH = bit_serial_gate_ctrl_pkg::WIDTH_DEFAULT
) ();

  logic             req0_valid;
  logic             req0_ready;
  logic [2:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [2:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_id;
  logic             rsp_err;

  logic             busy;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_data, rsp_id, rsp_err,
    input  busy
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_data, rsp_id, rsp_err,
    output busy
  );

endinterface

// File: rtl/bit_serial_gate_ctrl_gates.sv
// One-bit gate unit: every logic function is derived purely from 2-input NORs,
// all five results are offered in parallel for the caller to select from.
module basic_gates_using_nor (
  input  logic a,
  input  logic b,
  output logic y_and,
  output logic y_or,
  output logic y_not,
  output logic y_xor,
  output logic y_xnor
);

  function automatic logic nor2(input logic x, input logic y);
    return ~(x | y);
  endfunction

  logic n_a;
  logic n_b;
  logic n_ab;

  assign n_a  = nor2(a, a);
  assign n_b  = nor2(b, b);
  assign n_ab = nor2(a, b);

  assign y_not  = n_a;
  assign y_or   = nor2(n_ab, n_ab);
  assign y_and  = nor2(n_a, n_b);
  // a^b is low exactly when both are high (y_and) or both are low (n_ab).
  assign y_xor  = nor2(y_and, n_ab);
  assign y_xnor = nor2(y_xor, y_xor);

endmodule

// File: rtl/bit_serial_gate_ctrl.sv
// Two-requester round-robin controller evaluating a bitwise op one bit per cycle, LSB first;
// response appears WIDTH+1 cycles after acceptance and is held until the consumer takes it.
module bit_serial_gate_ctrl
  import bit_serial_gate_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input logic                 clk,
  input logic                 rst_n,
  bit_serial_gate_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic             ptr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] result;
  logic [2:0]       op_reg;
  logic             id_reg;

  logic             rsp_valid_reg;
  logic [WIDTH-1:0] rsp_data_reg;
  logic             rsp_id_reg;
  logic             rsp_err_reg;
  logic             busy_reg;

  logic grant0;
  logic grant1;

  // Readies are combinational from IDLE state; gated by rst_n so nothing is accepted in reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && state == ST_IDLE) begin
      if (bus.req0_valid && (!bus.req1_valid || !ptr)) begin
        grant0 = 1'b1;
      end else if (bus.req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  logic bit_a;
  logic bit_b;
  logic g_and;
  logic g_or;
  logic g_not;
  logic g_xor;
  logic g_xnor;
  logic gate_bit;

  assign bit_a = a_reg[cnt];
  assign bit_b = b_reg[cnt];

  basic_gates_using_nor u_gate (
    .a      (bit_a),
    .b      (bit_b),
    .y_and  (g_and),
    .y_or   (g_or),
    .y_not  (g_not),
    .y_xor  (g_xor),
    .y_xnor (g_xnor)
  );

  always_comb begin
    gate_bit = 1'b0;
    case (op_reg)
      OP_AND:  gate_bit = g_and;
      OP_OR:   gate_bit = g_or;
      OP_NOT:  gate_bit = g_not;
      OP_XOR:  gate_bit = g_xor;
      OP_XNOR: gate_bit = g_xnor;
      default: gate_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      ptr           <= 1'b0;
      cnt           <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      result        <= '0;
      op_reg        <= OP_AND;
      id_reg        <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_id_reg    <= 1'b0;
      rsp_err_reg   <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant0 || grant1) begin
            op_reg   <= grant1 ? bus.req1_op : bus.req0_op;
            a_reg    <= grant1 ? bus.req1_a  : bus.req0_a;
            b_reg    <= grant1 ? bus.req1_b  : bus.req0_b;
            id_reg   <= grant1;
            ptr      <= grant0;
            cnt      <= '0;
            result   <= '0;
            busy_reg <= 1'b1;
            state    <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          result[cnt] <= gate_bit;
          // Counter parks on the last index rather than wrapping.
          if (cnt == CW'(WIDTH - 1)) begin
            state <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_RESP: begin
          // First RESP cycle loads the response register; afterwards it is frozen until taken.
          if (!rsp_valid_reg) begin
            rsp_valid_reg <= 1'b1;
            rsp_data_reg  <= result;
            rsp_id_reg    <= id_reg;
            rsp_err_reg   <= !op_legal(op_reg);
          end else if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state         <= ST_IDLE;
          end
        end

        default: begin
          state    <= ST_IDLE;
          busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_id    = rsp_id_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_bit_serial_gate_ctrl.sv
// Bench for bit_serial_gate_ctrl: directed vector table, multi-cycle corner sequences,
// and randomized operations checked against a word-level reference model.
module tb_bit_serial_gate_ctrl;
  import bit_serial_gate_ctrl_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bit_serial_gate_ctrl_if #(.WIDTH(W)) bus ();

  bit_serial_gate_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Whole-word reference of the bitwise operations.
  function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~a;
      3'd3:    return a ^ b;
      3'd4:    return ~(a ^ b);
      default: return '0;
    endcase
  endfunction

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_op = 3'd0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = 3'd0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready  = 1'b0;
  endtask

  task automatic drive_req(input int r, input logic v, input logic [2:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
    if (r == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  function automatic logic rdy(input int r);
    return (r == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  // Full transaction on one requester; hold = cycles rsp_ready is kept low after rsp_valid.
  task automatic run_op(input int r, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_d,
                        input logic exp_e, input int hold, input string tag);
    logic got;
    int lat;
    got = 1'b0;
    drive_req(r, 1'b1, op, a, b);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = rdy(r);
    end
    if (!got) begin
      chk({tag, "_grant_timeout"}, 32'd0, 32'd1);
      idle_inputs();
      return;
    end
    chk({tag, "_other_ready"}, {31'd0, rdy(1 - r)}, 32'd0);
    @(posedge clk); #1;
    // Scramble the requester inputs: the operation in flight must not notice.
    drive_req(r, 1'b0, 3'($urandom), W'($urandom), W'($urandom));
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.rsp_valid && lat < 40);
    chk({tag, "_latency"}, lat, W + 1);
    chk({tag, "_data"}, bus.rsp_data, exp_d);
    chk({tag, "_id"}, {31'd0, bus.rsp_id}, r);
    chk({tag, "_err"}, {31'd0, bus.rsp_err}, {31'd0, exp_e});
    if (hold > 0) begin
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk({tag, "_hold_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
        chk({tag, "_hold_data"}, bus.rsp_data, exp_d);
        chk({tag, "_hold_id"}, {31'd0, bus.rsp_id}, r);
        chk({tag, "_hold_err"}, {31'd0, bus.rsp_err}, {31'd0, exp_e});
        chk({tag, "_hold_readies"}, {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
      end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk({tag, "_idle_after"}, {30'd0, bus.busy, bus.rsp_valid}, 32'd0);
    idle_inputs();
  endtask

  typedef struct {
    int         r;
    logic [2:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_d;
    logic       exp_e;
    int         hold;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int grants[$];
    int ids[$];
    logic got;

    vecs[0] = '{0, OP_AND,  8'hF0, 8'h3C, 8'h30, 1'b0, 0};
    vecs[1] = '{1, OP_XOR,  8'hA5, 8'h0F, 8'hAA, 1'b0, 0};
    vecs[2] = '{0, OP_XNOR, 8'hA5, 8'h0F, 8'h55, 1'b0, 0};
    vecs[3] = '{1, OP_NOT,  8'hA5, 8'hFF, 8'h5A, 1'b0, 0};
    vecs[4] = '{0, OP_OR,   8'hF0, 8'h3C, 8'hFC, 1'b0, 5};
    vecs[5] = '{0, 3'd6,    8'hFF, 8'h00, 8'h00, 1'b1, 0};
    vecs[6] = '{1, 3'd7,    8'hFF, 8'hFF, 8'h00, 1'b1, 0};
    vecs[7] = '{0, OP_AND,  8'hFF, 8'hFF, 8'hFF, 1'b0, 2};

    // Reset: requests pending must not be acknowledged.
    idle_inputs();
    rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_readies", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("reset_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("reset_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
    chk("reset_rsp_data", bus.rsp_data, 32'd0);
    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Contention: both requesters valid continuously, consumer always ready.
    drive_req(0, 1'b1, OP_AND, 8'hF0, 8'h3C);
    drive_req(1, 1'b1, OP_XOR, 8'hA5, 8'h0F);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 200 && ids.size() < 4; i++) begin
      @(negedge clk);
      if (bus.req0_ready && bus.req1_ready) chk("both_ready", 32'd1, 32'd0);
      if (bus.req0_ready) grants.push_back(0);
      if (bus.req1_ready) grants.push_back(1);
      if (bus.rsp_valid) begin
        ids.push_back(int'(bus.rsp_id));
        chk("cont_data", bus.rsp_data,
            bus.rsp_id ? ref_op(OP_XOR, 8'hA5, 8'h0F) : ref_op(OP_AND, 8'hF0, 8'h3C));
      end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(posedge clk); #1;
    idle_inputs();
    chk("cont_count", ids.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("cont_grant%0d", i), (i < grants.size()) ? grants[i] : -1, i % 2);
      chk($sformatf("cont_id%0d", i), (i < ids.size()) ? ids[i] : -1, i % 2);
    end
    @(posedge clk); #1;

    // Directed vector table.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].r, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_d, vecs[i].exp_e,
             vecs[i].hold, $sformatf("vec%0d", i));
    end

    // Reset during SHIFT at cnt=3, after a req0 grant left the pointer on req1.
    got = 1'b0;
    drive_req(0, 1'b1, OP_XOR, 8'h12, 8'h34);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bus.req0_ready;
    end
    chk("midrst_grant", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_busy_before", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("midrst_readies", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_first_grant", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd1);
    idle_inputs();
    @(posedge clk); #1;
    run_op(0, OP_NOT, 8'h3C, 8'h00, 8'hC3, 1'b0, 0, "post_rst");

    // Randomized operations against the reference model.
    for (int i = 0; i < 30; i++) begin
      int r;
      logic [2:0] op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      r  = int'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7));
      a  = W'($urandom);
      b  = W'($urandom);
      run_op(r, op, a, b, ref_op(op, a, b), op > 3'd4, int'($urandom_range(0, 3)),
             $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
